ws_tile_controller: RTL
=======================

WS_TILE_CONTROLLER -- requirements
Module: ws_tile_controller

Interface
REQ-001 SHALL provide parameter ARRAY_ROWS, default 3: PE array rows, one psum output channel per row.
REQ-002 SHALL provide parameter ARRAY_COLS, default 3: PE array columns, one iact input channel per column, and weight rows per tile.
REQ-003 SHALL provide parameter ADDR_W, default 32: width of every address port.
REQ-004 SHALL provide parameter DIM_W, default 8: width of the dimension inputs and of tile_idx.
REQ-005 SHALL provide: clk  in  1  single clock, all logic on its rising edge.
REQ-006 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL provide: start  in  1  synchronous request to begin a job.
REQ-008 SHALL provide: abort  in  1  synchronous job cancel.
REQ-009 SHALL provide: cfg_num_vectors  in  DIM_W  iact vectors streamed per tile (N).
REQ-010 SHALL provide: cfg_num_tiles  in  DIM_W  weight tiles per job (T).
REQ-011 SHALL provide: cfg_weight_base, cfg_iact_base, cfg_psum_base  in  ADDR_W each  block-RAM base addresses.
REQ-012 SHALL provide: load_weight  out  1, and weight_addr  out  ADDR_W.
REQ-013 SHALL provide: load_iact  out  ARRAY_COLS, and iact_addr  out  ARRAY_COLS x ADDR_W.
REQ-014 SHALL provide: psum_valid  out  ARRAY_ROWS, and psum_addr  out  ARRAY_ROWS x ADDR_W.
REQ-015 SHALL provide: busy, done, cfg_err  out  1 each; tile_idx  out  DIM_W  current tile.

Function
REQ-016 SHALL implement states IDLE, LOAD_WEIGHTS, COMPUTE, DONE.
REQ-017 In IDLE or DONE, start=1 with N>0 and T>0 SHALL latch all cfg_* inputs, clear tile_idx and cfg_err, and enter LOAD_WEIGHTS on the next edge.
REQ-018 In IDLE or DONE, start=1 with N=0 or T=0 SHALL set cfg_err=1 and leave the state unchanged.
REQ-019 cfg_err SHALL stay set until the next accepted start or a reset.
REQ-020 start SHALL be ignored in LOAD_WEIGHTS and COMPUTE; cfg_* changes after a job is accepted SHALL have no effect on that job.
REQ-021 LOAD_WEIGHTS SHALL last exactly ARRAY_COLS cycles with load_weight=1.
REQ-022 During LOAD_WEIGHTS, weight_addr SHALL equal weight_base + tile_idx*ARRAY_COLS + w, where w = 0..ARRAY_COLS-1 is the cycle index in the state.
REQ-023 After LOAD_WEIGHTS, the block SHALL enter COMPUTE with counter c=0.
REQ-024 COMPUTE SHALL last exactly N+ARRAY_ROWS+ARRAY_COLS cycles (c = 0 .. N+ARRAY_ROWS+ARRAY_COLS-1).
REQ-025 In COMPUTE, load_iact[j] SHALL be 1 iff j <= c < j+N.
REQ-026 When load_iact[j]=1, iact_addr[j] SHALL equal iact_base + j*N + (c-j); iact is reused unchanged for every tile.
REQ-027 In COMPUTE, psum_valid[i] SHALL be 1 iff ARRAY_COLS+1+i <= c < ARRAY_COLS+1+i+N.
REQ-028 When psum_valid[i]=1, psum_addr[i] SHALL equal psum_base + (tile_idx*ARRAY_ROWS+i)*N + (c-ARRAY_COLS-1-i).
REQ-029 All address arithmetic SHALL be modulo 2^ADDR_W, with no saturation or error.
REQ-030 At the end of COMPUTE, if tile_idx < T-1 the block SHALL increment tile_idx and re-enter LOAD_WEIGHTS; otherwise it SHALL enter DONE.
REQ-031 done SHALL be 1 exactly while in DONE.
REQ-032 busy SHALL be 1 exactly while in LOAD_WEIGHTS or COMPUTE.
REQ-033 Outside their states, load_weight, load_iact and psum_valid SHALL be 0.
REQ-034 Address outputs SHALL be don't-care while their strobe is 0.
REQ-035 abort=1 in any state SHALL force IDLE on the next edge, clearing counters, tile_idx and done; abort SHALL have priority over start in the same cycle.
REQ-036 The counters SHALL be wide enough for N, T and ARRAY_ROWS+ARRAY_COLS at their maxima without overflow.

Reset
REQ-037 While rst_n=0, the block SHALL be asynchronously in IDLE with every output, counter and latched cfg register at 0.
REQ-038 Reset asserted mid-job SHALL drop all strobes immediately, with no completion or done.

Verification (ARRAY_ROWS=ARRAY_COLS=3, bases weight 0x100, iact 0x200, psum 0x300)
REQ-039 Single tile: start with N=3, T=1 -> load_weight for 3 cycles at 0x100..0x102; COMPUTE for 9 cycles; load_iact = 100,110,111,011,001; psum_valid[0] at c=4..6 with psum_addr[0] = 0x300..0x302; psum_valid[2] at c=6..8 with psum_addr[2] = 0x306..0x308; then done=1.
REQ-040 Two tiles: N=2, T=2 -> second LOAD_WEIGHTS addresses 0x103..0x105; tile 1 psum_addr[0] = 0x306,0x307; iact_addr[1] = 0x202,0x203 in both tiles; done after the second COMPUTE.
REQ-041 Bad config: start with N=0 -> cfg_err=1, state IDLE, no strobe; a following start with N=1, T=1 clears cfg_err and runs.
REQ-042 Abort: abort at c=2 of COMPUTE -> next cycle IDLE, all strobes 0, busy=0, done=0; a following start runs a full job correctly.
REQ-043 Async reset: rst_n low in the 2nd LOAD_WEIGHTS cycle -> outputs 0 before the next clock edge; after release, state IDLE.
REQ-044 Start handling: start pulses during COMPUTE are ignored; start in DONE clears done and begins a new job next cycle.

Source files
------------

// File: rtl/ws_tile_controller.sv
// rtl/ws_tile_controller.sv - weight-stationary tile sequencer: weight loads, skewed iact feed, psum drain
module ws_tile_controller #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int ADDR_W     = 32,
    parameter int DIM_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DIM_W-1:0]             cfg_num_vectors,
    input  logic [DIM_W-1:0]             cfg_num_tiles,
    input  logic [ADDR_W-1:0]            cfg_weight_base,
    input  logic [ADDR_W-1:0]            cfg_iact_base,
    input  logic [ADDR_W-1:0]            cfg_psum_base,
    output logic                         load_weight,
    output logic [ADDR_W-1:0]            weight_addr,
    output logic [ARRAY_COLS-1:0]        load_iact,
    output logic [ARRAY_COLS*ADDR_W-1:0] iact_addr,
    output logic [ARRAY_ROWS-1:0]        psum_valid,
    output logic [ARRAY_ROWS*ADDR_W-1:0] psum_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [DIM_W-1:0]             tile_idx
);
    // Counter holds N + ARRAY_ROWS + ARRAY_COLS with headroom, and also the weight-load index.
    localparam int CNT_W = DIM_W + $clog2(ARRAY_ROWS + ARRAY_COLS + 1) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_WEIGHTS, COMPUTE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIM_W-1:0]   tile_idx_q, tile_idx_d;
    logic [DIM_W-1:0]   num_vec_q, num_vec_d;
    logic [DIM_W-1:0]   num_tiles_q, num_tiles_d;
    logic [ADDR_W-1:0]  wbase_q, wbase_d;
    logic [ADDR_W-1:0]  ibase_q, ibase_d;
    logic [ADDR_W-1:0]  pbase_q, pbase_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   n_ext;
    logic [CNT_W-1:0]   last_c;

    assign n_ext  = CNT_W'(num_vec_q);
    assign last_c = n_ext + CNT_W'(ARRAY_ROWS + ARRAY_COLS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tile_idx_q  <= '0;
            num_vec_q   <= '0;
            num_tiles_q <= '0;
            wbase_q     <= '0;
            ibase_q     <= '0;
            pbase_q     <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_idx_q  <= tile_idx_d;
            num_vec_q   <= num_vec_d;
            num_tiles_q <= num_tiles_d;
            wbase_q     <= wbase_d;
            ibase_q     <= ibase_d;
            pbase_q     <= pbase_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_idx_d  = tile_idx_q;
        num_vec_d   = num_vec_q;
        num_tiles_d = num_tiles_q;
        wbase_d     = wbase_q;
        ibase_d     = ibase_q;
        pbase_d     = pbase_q;
        cfg_err_d   = cfg_err_q;
        if (abort) begin
            state_d    = IDLE;
            cnt_d      = '0;
            tile_idx_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_num_vectors != '0 && cfg_num_tiles != '0) begin
                            state_d     = LOAD_WEIGHTS;
                            cnt_d       = '0;
                            tile_idx_d  = '0;
                            cfg_err_d   = 1'b0;
                            num_vec_d   = cfg_num_vectors;
                            num_tiles_d = cfg_num_tiles;
                            wbase_d     = cfg_weight_base;
                            ibase_d     = cfg_iact_base;
                            pbase_d     = cfg_psum_base;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                LOAD_WEIGHTS: begin
                    if (cnt_q == CNT_W'(ARRAY_COLS - 1)) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (cnt_q == last_c) begin
                        cnt_d = '0;
                        if (tile_idx_q != num_tiles_q - 1'b1) begin
                            state_d    = LOAD_WEIGHTS;
                            tile_idx_d = tile_idx_q + 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Addresses are forced to zero while their strobe is low so reset shows all-zero outputs.
    always_comb begin
        load_weight = (state_q == LOAD_WEIGHTS);
        weight_addr = '0;
        load_iact   = '0;
        iact_addr   = '0;
        psum_valid  = '0;
        psum_addr   = '0;
        if (load_weight) begin
            weight_addr = wbase_q + ADDR_W'(tile_idx_q) * ADDR_W'(ARRAY_COLS) + ADDR_W'(cnt_q);
        end
        for (int j = 0; j < ARRAY_COLS; j++) begin
            if (state_q == COMPUTE && cnt_q >= CNT_W'(j) && cnt_q < CNT_W'(j) + n_ext) begin
                load_iact[j] = 1'b1;
                iact_addr[j*ADDR_W +: ADDR_W] = ibase_q + ADDR_W'(j) * ADDR_W'(num_vec_q)
                                              + ADDR_W'(cnt_q - CNT_W'(j));
            end
        end
        // Row i drains once the skewed wavefront has crossed all columns plus i rows.
        for (int i = 0; i < ARRAY_ROWS; i++) begin
            if (state_q == COMPUTE && cnt_q >= CNT_W'(ARRAY_COLS + 1 + i)
                && cnt_q < CNT_W'(ARRAY_COLS + 1 + i) + n_ext) begin
                psum_valid[i] = 1'b1;
                psum_addr[i*ADDR_W +: ADDR_W] = pbase_q
                    + (ADDR_W'(tile_idx_q) * ADDR_W'(ARRAY_ROWS) + ADDR_W'(i)) * ADDR_W'(num_vec_q)
                    + ADDR_W'(cnt_q - CNT_W'(ARRAY_COLS + 1 + i));
            end
        end
    end

    assign busy     = (state_q == LOAD_WEIGHTS) || (state_q == COMPUTE);
    assign done     = (state_q == DONE);
    assign cfg_err  = cfg_err_q;
    assign tile_idx = tile_idx_q;

endmodule
